fetch_unit: RTL and testbench

- Instruction-fetch front end: holds the architectural PC and issues word reads to instruction memory over a valid/ready request and valid-only response interface.
- Hands each fetched instruction and its PC to decode over a valid/ready handshake.
- Consumes the redirect (branch taken, plus target) produced by the execute stage, so it is the receiving end of the execute result path.
- Allows at most one outstanding memory request; squashes wrong-path fetches.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit constants and FSM state type.
// S_FAULT exists only when FETCH_MISALIGN_EN is defined.
package fetch_unit_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
  localparam int          INST_BYTES    = 4;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem read, redirect squashing, decode handoff.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets trap into a sticky fault state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(BASE_ADDR_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DWIDTH-1:0] inst_o,
  output logic [AWIDTH-1:0] inst_pc_o
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              misaligned_o
`endif
);

  fetch_state_e      r_state;
  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_inst_pc;
  logic [DWIDTH-1:0] r_inst;
  logic              r_kill;
  logic [AWIDTH-1:0] w_tgt;
  logic [AWIDTH-1:0] w_pc_next;

  // Word-align the target so pc_q can never hold a misaligned address.
  assign w_tgt     = redirect_pc_i & ~AWIDTH'(3);
  assign w_pc_next = r_pc + AWIDTH'(INST_BYTES);

  assign imem_req_valid_o = (r_state == S_REQ);
  assign imem_req_addr_o  = r_pc;
  assign inst_valid_o     = (r_state == S_HOLD) && !redirect_i;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;

`ifdef FETCH_MISALIGN_EN
  logic r_misaligned;
  logic w_bad_tgt;
  assign w_bad_tgt    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign misaligned_o = r_misaligned;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pc      <= BASE_ADDR;
      r_kill    <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= BASE_ADDR;
`ifdef FETCH_MISALIGN_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_EN
      if (w_bad_tgt) begin
        r_state      <= S_FAULT;
        r_misaligned <= 1'b1;
      end else
`endif
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (redirect_i) r_pc <= w_tgt;
        end
        S_REQ: begin
          // Once accepted, the request is in flight and its answer must be squashed.
          if (redirect_i) begin
            r_pc <= w_tgt;
            if (imem_req_ready_i) r_kill <= 1'b1;
          end
          if (imem_req_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_i) r_pc <= w_tgt;
          if (imem_rsp_valid_i) begin
            if (r_kill || redirect_i) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst    <= imem_rsp_data_i;
              r_inst_pc <= r_pc;
              r_state   <= S_HOLD;
            end
          end else if (redirect_i) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            r_pc    <= w_tgt;
            r_state <= S_REQ;
          end else if (inst_ready_i) begin
            r_pc    <= w_pc_next;
            r_state <= S_REQ;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level PC/instruction-stream model.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
`ifdef FETCH_MISALIGN_EN
  logic        misaligned_o;
`endif

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
`ifdef FETCH_MISALIGN_EN
    ,
    .misaligned_o     (misaligned_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // stimulus knobs (percentages / latency range in cycles)
  int k_ready = 100, k_iready = 100, k_redir = 0, k_lat_min = 1, k_lat_max = 1;
  bit k_const = 1'b0;
  bit f_redir = 1'b0;
  logic [31:0] f_tgt = '0;

  // memory and architectural model
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  logic [31:0] model_pc = BASE;
  int          n_acc = 0;
  int          n_cyc = 0;
  bit          last_ivalid = 1'b0;
  bit          seen_req = 1'b0;
  logic [31:0] hand_pc[$];
  int          hand_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (k_const) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    case ($urandom_range(3))
      0:       t = $urandom;
      1:       t = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
      default: t = BASE + ($urandom_range(255) << 2);
    endcase
`ifdef FETCH_MISALIGN_EN
    t[1:0] = 2'b00;
`else
    if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
`endif
    return t;
  endfunction

  // One clock: drive inputs on negedge, observe and update the model just after.
  task automatic cycle();
    @(negedge clk_i);
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = $urandom;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = memf(mem_addr);
        mem_pend         = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_req_ready_i = ($urandom_range(99) < k_ready);
    inst_ready_i     = ($urandom_range(99) < k_iready);
    if (f_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = f_tgt;
      f_redir       = 1'b0;
    end else if ($urandom_range(99) < k_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = rand_tgt();
    end else begin
      redirect_i    = 1'b0;
    end
    #1;
    n_cyc++;
    last_ivalid = inst_valid_o;
    seen_req    = seen_req | imem_req_valid_o;
    if (redirect_i) chk("redir_ivalid", 32'(inst_valid_o), 32'd0);
    if (imem_req_valid_o) chk("req_addr", imem_req_addr_o, model_pc);
    if (imem_req_valid_o && imem_req_ready_i) begin
      chk("one_outstanding", 32'(mem_pend), 32'd0);
      mem_pend = 1'b1;
      mem_addr = imem_req_addr_o;
      mem_cnt  = $urandom_range(k_lat_max, k_lat_min);
      n_acc++;
    end
    if (inst_valid_o && inst_ready_i) begin
      chk("hand_pc", inst_pc_o, model_pc);
      chk("hand_inst", inst_o, memf(model_pc));
      hand_pc.push_back(inst_pc_o);
      hand_cyc.push_back(n_cyc);
      model_pc = model_pc + 32'd4;
    end
    if (redirect_i) model_pc = redirect_pc_i & ~32'd3;
  endtask

  // Assert reset mid-cycle, confirm outputs drop immediately, release on a negedge.
  task automatic do_reset();
    redirect_i       = 1'b0;
    imem_rsp_valid_i = 1'b0;
    rst_ni           = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, BASE);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    mem_pend = 1'b0;
    model_pc = BASE;
    hand_pc.delete();
    hand_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nh;
    int acc0;
    // zero-wait streaming: one handoff every 3 cycles
    k_const = 1'b1;
    do_reset();
    repeat (12) cycle();
    chk("a_count", 32'(hand_pc.size() >= 3), 32'd1);
    if (hand_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("a_pc", hand_pc[i], BASE + 32'(4 * i));
      for (int i = 1; i < 3; i++) chk("a_gap", 32'(hand_cyc[i] - hand_cyc[i-1]), 32'd3);
    end

    // request held while memory is not ready
    k_const = 1'b0;
    do_reset();
    n_acc   = 0;
    k_ready = 0;
    repeat (4) cycle();
    chk("b_no_accept", 32'(n_acc), 32'd0);
    k_ready   = 100;
    k_lat_min = 3;
    k_lat_max = 3;
    cycle();
    chk("b_accept", 32'(n_acc), 32'd1);

    // redirect during the wait, response arrives two cycles later and is squashed
    k_lat_min = 1;
    k_lat_max = 1;
    f_redir   = 1'b1;
    f_tgt     = 32'h0100_0100;
    hand_pc.delete();
    repeat (9) cycle();
    chk("c_count", 32'(hand_pc.size() >= 1), 32'd1);
    if (hand_pc.size() >= 1) chk("c_first_pc", hand_pc[0], 32'h0100_0100);

    // decode stalls in hold, then redirect with ready the same cycle
    k_iready = 0;
    for (int i = 0; i < 20 && !last_ivalid; i++) cycle();
    chk("d_hold", 32'(last_ivalid), 32'd1);
    repeat (4) cycle();
    nh       = hand_pc.size();
    k_iready = 100;
    f_redir  = 1'b1;
    f_tgt    = 32'h0100_0040;
    cycle();
    chk("d_ivalid", 32'(last_ivalid), 32'd0);
    chk("d_no_hand", 32'(hand_pc.size()), 32'(nh));
    hand_pc.delete();
    repeat (8) cycle();
    chk("d_count", 32'(hand_pc.size() >= 1), 32'd1);
    if (hand_pc.size() >= 1) chk("d_first_pc", hand_pc[0], 32'h0100_0040);

    // PC wraps past the top of the address space
    f_redir = 1'b1;
    f_tgt   = 32'hFFFF_FFFC;
    hand_pc.delete();
    repeat (16) cycle();
    chk("e_count", 32'(hand_pc.size() >= 2), 32'd1);
    if (hand_pc.size() >= 2) begin
      chk("e_pc0", hand_pc[0], 32'hFFFF_FFFC);
      chk("e_pc1", hand_pc[1], 32'h0000_0000);
    end

    // reset while a request is outstanding
    k_lat_min = 5;
    k_lat_max = 5;
    acc0 = n_acc;
    for (int i = 0; i < 20 && n_acc == acc0; i++) cycle();
    chk("f_accept", 32'(n_acc > acc0), 32'd1);
    cycle();
    do_reset();
    k_lat_min = 1;
    k_lat_max = 1;
    repeat (10) cycle();
    chk("f_count", 32'(hand_pc.size() >= 1), 32'd1);
    if (hand_pc.size() >= 1) chk("f_first_pc", hand_pc[0], BASE);

    // randomized traffic
    k_ready   = 70;
    k_iready  = 60;
    k_redir   = 8;
    k_lat_min = 1;
    k_lat_max = 4;
    hand_pc.delete();
    repeat (3000) cycle();
    chk("rand_progress", 32'(hand_pc.size() > 100), 32'd1);

`ifdef FETCH_MISALIGN_EN
    k_redir = 0;
    k_ready = 100;
    do_reset();
    f_redir = 1'b1;
    f_tgt   = 32'h0100_0002;
    cycle();
    seen_req = 1'b0;
    repeat (5) cycle();
    chk("g_misaligned", 32'(misaligned_o), 32'd1);
    chk("g_no_req", 32'(seen_req), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
